cart_bus_arbiter: RTL and testbench

// - Owns the single cartridge SDRAM channel (ch0): shares it between ROM-download writes (hps ioctl) and minx CPU fetches.
// - Sequences each access with a proper request/busy handshake and generates ioctl wait backpressure.
// - Keeps a 1-entry read cache so repeated fetches of the same byte skip SDRAM.
// - Sits in emu between hps_io/minx and sdram; replaces the ad-hoc ch0 address/rd/wr muxing.

---
 rtl/pm_pkg.sv | 12 +
 rtl/cart_bus_arbiter_if.sv | 30 +++
 rtl/cart_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_cart_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pm_pkg.sv
// Shared types and constants for the Pokemon Mini cartridge bus logic.
package pm_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ARM,
        ARB_WAIT
    } arb_state_t;

    localparam logic [7:0] CART_OPEN_BUS = 8'hFF;

endpackage

// File: rtl/cart_bus_arbiter_if.sv
// Bus bundle between the cartridge arbiter and its three neighbours: ioctl, minx and sdram ch0.
interface cart_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 21
) ();
    logic              dl_active;
    logic              dl_wr;
    logic [24:0]       dl_addr;
    logic [15:0]       dl_data;
    logic              dl_wait;
    logic              cpu_rd;
    logic [23:0]       cpu_addr;
    logic [7:0]        cpu_data;
    logic              cpu_ready;
    logic [ADDR_W-1:0] sd_addr;
    logic              sd_rd;
    logic              sd_wr;
    logic [15:0]       sd_din;
    logic [7:0]        sd_dout;
    logic              sd_busy;

    modport master (
        input  dl_active, dl_wr, dl_addr, dl_data, cpu_rd, cpu_addr, sd_dout, sd_busy,
        output dl_wait, cpu_data, cpu_ready, sd_addr, sd_rd, sd_wr, sd_din
    );

    modport slave (
        output dl_active, dl_wr, dl_addr, dl_data, cpu_rd, cpu_addr, sd_dout, sd_busy,
        input  dl_wait, cpu_data, cpu_ready, sd_addr, sd_rd, sd_wr, sd_din
    );
endinterface

// File: rtl/cart_bus_arbiter.sv
// Shares sdram ch0 between ROM-download writes and minx fetches, with a 1-entry write
// buffer, a 1-entry read cache and a busy timeout.
module cart_bus_arbiter
    import pm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 21,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    cart_bus_arbiter_if.master bus,
    output logic               timeout_err
);

    arb_state_t        state_q, state_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic              wbuf_full_q, wbuf_full_d;
    logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
    logic [15:0]       wbuf_data_q, wbuf_data_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [7:0]        cache_data_q, cache_data_d;
    logic [7:0]        cpu_data_q, cpu_data_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic              sd_rd_q, sd_rd_d;
    logic              sd_wr_q, sd_wr_d;
    logic [15:0]       sd_din_q, sd_din_d;
    logic              tmo_err_q, tmo_err_d;
    logic              dl_active_q;

    logic              wr_accept, rd_new, rd_hit, dl_fall, tmo_hit;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{bus.dl_addr[24:ADDR_W], bus.cpu_addr[23:ADDR_W]};

    assign wr_accept = bus.dl_wr & ~wbuf_full_q;
    assign rd_new    = bus.cpu_rd & ~rd_pend_q;
    // A simultaneous download strobe may target the cached byte, so it blocks the hit.
    assign rd_hit    = cache_valid_q & (cache_addr_q == bus.cpu_addr[ADDR_W-1:0]) & ~bus.dl_wr;
    assign dl_fall   = dl_active_q & ~bus.dl_active;
    assign tmo_hit   = (cnt_q == 10'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_wr_d       = op_wr_q;
        wbuf_full_d   = wbuf_full_q;
        wbuf_addr_d   = wbuf_addr_q;
        wbuf_data_d   = wbuf_data_q;
        rd_pend_d     = rd_pend_q;
        rd_addr_d     = rd_addr_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        cpu_data_d    = cpu_data_q;
        cpu_ready_d   = 1'b0;
        sd_addr_d     = sd_addr_q;
        sd_rd_d       = 1'b0;
        sd_wr_d       = 1'b0;
        sd_din_d      = sd_din_q;
        tmo_err_d     = tmo_err_q;

        if (wr_accept) begin
            wbuf_full_d = 1'b1;
            wbuf_addr_d = bus.dl_addr[ADDR_W-1:0];
            wbuf_data_d = bus.dl_data;
        end

        if (rd_new) begin
            if (bus.dl_active) begin
                cpu_ready_d = 1'b1;
                cpu_data_d  = CART_OPEN_BUS;
            end else if (rd_hit) begin
                cpu_ready_d = 1'b1;
                cpu_data_d  = cache_data_q;
            end else begin
                rd_pend_d = 1'b1;
                rd_addr_d = bus.cpu_addr[ADDR_W-1:0];
            end
        end

        unique case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (!bus.sd_busy && wbuf_full_q) begin
                    sd_wr_d       = 1'b1;
                    sd_addr_d     = wbuf_addr_q;
                    sd_din_d      = wbuf_data_q;
                    op_wr_d       = 1'b1;
                    cache_valid_d = 1'b0;
                    state_d       = ARB_ARM;
                end else if (!bus.sd_busy && rd_pend_q) begin
                    sd_rd_d   = 1'b1;
                    sd_addr_d = rd_addr_q;
                    op_wr_d   = 1'b0;
                    state_d   = ARB_ARM;
                end
            end
            ARB_ARM, ARB_WAIT: begin
                if (state_q == ARB_WAIT && !bus.sd_busy) begin
                    state_d = ARB_IDLE;
                    if (op_wr_q) begin
                        wbuf_full_d = 1'b0;
                    end else begin
                        rd_pend_d     = 1'b0;
                        cpu_ready_d   = 1'b1;
                        cpu_data_d    = bus.sd_dout;
                        cache_valid_d = 1'b1;
                        cache_addr_d  = rd_addr_q;
                        cache_data_d  = bus.sd_dout;
                    end
                end else if (tmo_hit) begin
                    state_d   = ARB_IDLE;
                    tmo_err_d = 1'b1;
                    if (op_wr_q) begin
                        wbuf_full_d = 1'b0;
                    end else begin
                        rd_pend_d   = 1'b0;
                        cpu_ready_d = 1'b1;
                        cpu_data_d  = CART_OPEN_BUS;
                    end
                end else begin
                    cnt_d   = cnt_q + 10'd1;
                    state_d = ARB_WAIT;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Invalidations come last so they win over a fill completing in the same cycle.
        if (wr_accept || dl_fall) begin
            cache_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            cnt_q         <= '0;
            op_wr_q       <= 1'b0;
            wbuf_full_q   <= 1'b0;
            wbuf_addr_q   <= '0;
            wbuf_data_q   <= '0;
            rd_pend_q     <= 1'b0;
            rd_addr_q     <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            cpu_data_q    <= 8'h00;
            cpu_ready_q   <= 1'b0;
            sd_addr_q     <= '0;
            sd_rd_q       <= 1'b0;
            sd_wr_q       <= 1'b0;
            sd_din_q      <= '0;
            tmo_err_q     <= 1'b0;
            dl_active_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_wr_q       <= op_wr_d;
            wbuf_full_q   <= wbuf_full_d;
            wbuf_addr_q   <= wbuf_addr_d;
            wbuf_data_q   <= wbuf_data_d;
            rd_pend_q     <= rd_pend_d;
            rd_addr_q     <= rd_addr_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            cpu_data_q    <= cpu_data_d;
            cpu_ready_q   <= cpu_ready_d;
            sd_addr_q     <= sd_addr_d;
            sd_rd_q       <= sd_rd_d;
            sd_wr_q       <= sd_wr_d;
            sd_din_q      <= sd_din_d;
            tmo_err_q     <= tmo_err_d;
            dl_active_q   <= bus.dl_active;
        end
    end

    assign bus.dl_wait   = wbuf_full_q | (state_q != ARB_IDLE);
    assign bus.cpu_data  = cpu_data_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.sd_addr   = sd_addr_q;
    assign bus.sd_rd     = sd_rd_q;
    assign bus.sd_wr     = sd_wr_q;
    assign bus.sd_din    = sd_din_q;
    assign timeout_err   = tmo_err_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter with a small behavioural sdram ch0 model.
module tb_cart_bus_arbiter;

    logic clk_sys = 1'b0;
    logic reset_n;
    logic timeout_err;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;
    int busy_len = 4;
    int n;
    logic [7:0] next_dout = 8'h00;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    logic [15:0] dl_tab [3] = '{16'h1234, 16'h5678, 16'h9ABC};

    cart_bus_arbiter_if #(.ADDR_W(21)) bus ();

    cart_bus_arbiter #(
        .ADDR_W  (21),
        .TIMEOUT (15)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_dl_wait"}, bus.dl_wait, 0);
        check({tag, "_cpu_data"}, bus.cpu_data, 8'h00);
        check({tag, "_cpu_ready"}, bus.cpu_ready, 0);
        check({tag, "_sd_addr"}, bus.sd_addr, 0);
        check({tag, "_sd_rd"}, bus.sd_rd, 0);
        check({tag, "_sd_wr"}, bus.sd_wr, 0);
        check({tag, "_sd_din"}, bus.sd_din, 0);
        check({tag, "_tmo_err"}, timeout_err, 0);
    endtask

    // sdram ch0 model: busy rises half a cycle after the request and is seen for
    // busy_len cycles after the arbiter's blanking cycle.
    initial begin
        bus.sd_busy = 1'b0;
        bus.sd_dout = 8'h00;
    end

    always @(negedge clk_sys) begin
        if (bus.sd_rd || bus.sd_wr) begin
            check("sd_rd_wr_exclusive", bus.sd_rd & bus.sd_wr, 0);
            check("sd_pulse_width", (bus.sd_rd & prev_rd) | (bus.sd_wr & prev_wr), 0);
            busy_cnt = busy_len + 1;
            if (bus.sd_rd) begin
                rd_cnt++;
                bus.sd_dout = next_dout;
            end
            if (bus.sd_wr) wr_cnt++;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        bus.sd_busy = (busy_cnt != 0);
        prev_rd = bus.sd_rd;
        prev_wr = bus.sd_wr;
    end

    initial begin
        reset_n       = 1'b0;
        bus.dl_active = 1'b0;
        bus.dl_wr     = 1'b0;
        bus.dl_addr   = '0;
        bus.dl_data   = '0;
        bus.cpu_rd    = 1'b0;
        bus.cpu_addr  = '0;
        repeat (2) tick();
        reset_checks("rst_init");
        reset_n = 1'b1;
        tick();

        // ROM download: three buffered writes
        bus.dl_active = 1'b1;
        busy_len = 4;
        for (int i = 0; i < 3; i++) begin
            bus.dl_addr = 25'(2 * i);
            bus.dl_data = dl_tab[i];
            bus.dl_wr   = 1'b1;
            tick();
            bus.dl_wr = 1'b0;
            check("dl_wait_strobe", bus.dl_wait, 1);
            check("sd_wr_early", bus.sd_wr, 0);
            tick();
            check("sd_wr_issue", bus.sd_wr, 1);
            check("sd_wr_addr", bus.sd_addr, 32'(2 * i));
            check("sd_wr_din", bus.sd_din, dl_tab[i]);
            n = 0;
            while (bus.dl_wait && n < 20) begin
                tick();
                n++;
            end
            check("dl_wait_release", n, 6);
            check("wr_count", wr_cnt, i + 1);
        end
        bus.dl_active = 1'b0;
        tick();

        // Read miss then hit
        busy_len = 3;
        next_dout = 8'h5A;
        bus.cpu_addr = 24'h002100;
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        check("miss_no_early_ready", bus.cpu_ready, 0);
        n = 0;
        while (!bus.cpu_ready && n < 20) begin
            tick();
            n++;
        end
        check("miss_latency", n, 6);
        check("miss_data", bus.cpu_data, 8'h5A);
        check("miss_sd_rd_count", rd_cnt, 1);
        tick();
        check("ready_pulse", bus.cpu_ready, 0);

        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        check("hit_ready", bus.cpu_ready, 1);
        check("hit_data", bus.cpu_data, 8'h5A);
        repeat (3) tick();
        check("hit_no_sd_rd", rd_cnt, 1);

        // Collision on the cached address: write first, then a fresh read
        next_dout = 8'hC3;
        bus.dl_addr = 25'h002100;
        bus.dl_data = 16'hBEEF;
        bus.dl_wr = 1'b1;
        bus.cpu_rd = 1'b1;
        tick();
        bus.dl_wr = 1'b0;
        bus.cpu_rd = 1'b0;
        check("coll_no_stale_hit", bus.cpu_ready, 0);
        tick();
        check("coll_wr_first", bus.sd_wr, 1);
        check("coll_no_rd_yet", bus.sd_rd, 0);
        check("coll_wr_din", bus.sd_din, 16'hBEEF);
        n = 0;
        while (!bus.sd_rd && n < 20) begin
            tick();
            n++;
        end
        check("coll_rd_after_wr", n, 6);
        check("coll_rd_addr", bus.sd_addr, 32'h2100);
        n = 0;
        while (!bus.cpu_ready && n < 20) begin
            tick();
            n++;
        end
        check("coll_rd_latency", n, 5);
        check("coll_rd_data", bus.cpu_data, 8'hC3);
        check("coll_counts", {wr_cnt[15:0], rd_cnt[15:0]}, {16'd4, 16'd2});

        // End of a download drops the cached byte
        bus.dl_active = 1'b1;
        tick();
        bus.dl_active = 1'b0;
        tick();
        next_dout = 8'h77;
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        check("fall_miss", bus.cpu_ready, 0);
        n = 0;
        while (!bus.cpu_ready && n < 20) begin
            tick();
            n++;
        end
        check("fall_latency", n, 6);
        check("fall_data", bus.cpu_data, 8'h77);
        check("fall_sd_rd_count", rd_cnt, 3);

        // Reads during a download return open bus without touching sdram
        bus.dl_active = 1'b1;
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        check("guard_ready", bus.cpu_ready, 1);
        check("guard_data", bus.cpu_data, 8'hFF);
        repeat (3) tick();
        check("guard_no_sd_rd", rd_cnt, 3);
        bus.dl_active = 1'b0;
        tick();

        // Asynchronous reset in the middle of a read
        busy_len = 4;
        next_dout = 8'h11;
        bus.cpu_addr = 24'h000300;
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        repeat (3) tick();
        check("pre_reset_busy", bus.dl_wait, 1);
        reset_n = 1'b0;
        #1;
        reset_checks("rst_async");
        repeat (8) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("rst_dropped_rd", rd_cnt, 4);
        check("rst_no_ready", bus.cpu_ready, 0);

        // Stuck busy: timeout at cycle 16 after the request
        busy_len = 100;
        bus.cpu_addr = 24'h000400;
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        repeat (15) tick();
        check("tmo_not_yet", timeout_err, 0);
        check("tmo_still_busy", bus.dl_wait, 1);
        tick();
        check("tmo_err", timeout_err, 1);
        check("tmo_ready", bus.cpu_ready, 1);
        check("tmo_data", bus.cpu_data, 8'hFF);
        check("tmo_idle", bus.dl_wait, 0);
        tick();
        check("tmo_sticky", timeout_err, 1);
        check("tmo_ready_pulse", bus.cpu_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
